// File: rtl/adder_cla_4bit_pkg.sv
// rtl/adder_cla_4bit_pkg.sv - shared width, nibble type and result record for the 4-bit CLA adder
// The result record carries ovf only when ADDER_CLA_OVF_EN is defined.
package adder_cla_4bit_pkg;

    localparam int ADDER_WIDTH = 4;

    // Bit 0 is the MSB, bit 3 the LSB.
    typedef logic [0:ADDER_WIDTH-1] nibble_t;

    typedef struct packed {
        nibble_t s;
        logic    out_c;
        logic    p_out;
        logic    g_out;
        logic    valid;
`ifdef ADDER_CLA_OVF_EN
        logic    ovf;
`endif
    } result_t;

endpackage

// File: rtl/adder_cla_4bit_cla_unit_4.sv
// rtl/adder_cla_4bit_cla_unit_4.sv - 4-bit carry-lookahead unit (cla_unit_4)
// Every carry is a flat sum of products of g, p and inC; there is no ripple chain.
module cla_unit_4
    import adder_cla_4bit_pkg::*;
(
    input  nibble_t p,
    input  nibble_t g,
    input  logic    inC,
    output nibble_t c,
    output logic    outC,
    output logic    pOut,
    output logic    gOut
);

    always_comb begin
        c[3] = inC;
        c[2] = g[3] | (p[3] & inC);
        c[1] = g[2] | (p[2] & g[3]) | (p[2] & p[3] & inC);
        c[0] = g[1] | (p[1] & g[2]) | (p[1] & p[2] & g[3]) | (p[1] & p[2] & p[3] & inC);
    end

    assign gOut = g[0] | (p[0] & g[1]) | (p[0] & p[1] & g[2]) | (p[0] & p[1] & p[2] & g[3]);
    assign pOut = &p;
    assign outC = g[0] | (p[0] & c[0]);

endmodule

// File: rtl/adder_cla_4bit.sv
// rtl/adder_cla_4bit.sv - 4-bit carry-lookahead adder with optional output register (REG_OUT)
// Defining ADDER_CLA_OVF_EN adds the signed-overflow output ovf.
module adder_cla_4bit
    import adder_cla_4bit_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  nibble_t a,
    input  nibble_t b,
    input  logic    inC,
    input  logic    inValid,
    output nibble_t s,
    output logic    outC,
    output logic    outValid,
    output logic    pOut,
`ifdef ADDER_CLA_OVF_EN
    output logic    ovf,
`endif
    output logic    gOut
);

    nibble_t p;
    nibble_t g;
    nibble_t c;
    logic    cla_out_c;
    logic    cla_p_out;
    logic    cla_g_out;
    result_t res_d;
    result_t res_q;

    assign p = a ^ b;
    assign g = a & b;

    cla_unit_4 u_cla (
        .p    (p),
        .g    (g),
        .inC  (inC),
        .c    (c),
        .outC (cla_out_c),
        .pOut (cla_p_out),
        .gOut (cla_g_out)
    );

    always_comb begin
        res_d       = '0;
        res_d.s     = p ^ c;
        res_d.out_c = cla_out_c;
        res_d.p_out = cla_p_out;
        res_d.g_out = cla_g_out;
        res_d.valid = inValid;
`ifdef ADDER_CLA_OVF_EN
        // Carry into the MSB differing from carry out of it marks two's-complement overflow.
        res_d.ovf   = c[0] ^ cla_out_c;
`endif
    end

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    res_q <= '0;
                end else begin
                    res_q <= res_d;
                end
            end
        end else begin : g_comb
            assign res_q = res_d;
        end
    endgenerate

    assign s        = res_q.s;
    assign outC     = res_q.out_c;
    assign pOut     = res_q.p_out;
    assign gOut     = res_q.g_out;
    assign outValid = res_q.valid;
`ifdef ADDER_CLA_OVF_EN
    assign ovf      = res_q.ovf;
`endif

endmodule

// File: tb/tb_adder_cla_4bit.sv
// tb/tb_adder_cla_4bit.sv - self-checking bench for adder_cla_4bit, registered and combinational builds
module tb_adder_cla_4bit;

    typedef struct packed {
        logic [3:0] s;
        logic       c;
        logic       p;
        logic       g;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:3] a = '0;
    logic [0:3] b = '0;
    logic       inC = 1'b0;
    logic       inValid = 1'b0;

    logic [0:3] s_r, s_c;
    logic       outC_r, outC_c, outValid_r, outValid_c;
    logic       pOut_r, pOut_c, gOut_r, gOut_c;
`ifdef ADDER_CLA_OVF_EN
    logic       ovf_r, ovf_c;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_cla_4bit #(.REG_OUT(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .inC      (inC),
        .inValid  (inValid),
        .s        (s_r),
        .outC     (outC_r),
        .outValid (outValid_r),
        .pOut     (pOut_r),
`ifdef ADDER_CLA_OVF_EN
        .ovf      (ovf_r),
`endif
        .gOut     (gOut_r)
    );

    adder_cla_4bit #(.REG_OUT(1'b0)) dut_c (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .inC      (inC),
        .inValid  (inValid),
        .s        (s_c),
        .outC     (outC_c),
        .outValid (outValid_c),
        .pOut     (pOut_c),
`ifdef ADDER_CLA_OVF_EN
        .ovf      (ovf_c),
`endif
        .gOut     (gOut_c)
    );

    // Reference from plain integer arithmetic: group generate is the carry-out with no carry-in.
    function automatic exp_t model(input int av, input int bv, input int ci);
        exp_t e;
        int   tot, sa, sb, sr;
        tot  = av + bv + ci;
        e.s  = 4'(tot % 16);
        e.c  = (tot > 15);
        e.p  = ((av ^ bv) == 15);
        e.g  = ((av + bv) > 15);
        sa   = (av > 7) ? av - 16 : av;
        sb   = (bv > 7) ? bv - 16 : bv;
        sr   = sa + sb + ci;
        e.ov = (sr > 7) || (sr < -8);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({s_r, outC_r, pOut_r, gOut_r, outValid_r} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=00", {s_r, outC_r, pOut_r, gOut_r, outValid_r});
        end
`ifdef ADDER_CLA_OVF_EN
        checks++;
        if (ovf_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got=%b want=0", ovf_r);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_vectors();
        int   tv [6][3] = '{'{0, 0, 0}, '{10, 5, 0}, '{0, 5, 1}, '{1, 15, 1}, '{15, 0, 1}, '{15, 15, 1}};
        exp_t e;
        foreach (tv[i]) begin
            @(negedge clk);
            a = 4'(tv[i][0]); b = 4'(tv[i][1]); inC = 1'(tv[i][2]); inValid = 1'b1;
            e = model(tv[i][0], tv[i][1], tv[i][2]);
            #1;
            checks++;
            if ({s_c, outC_c, pOut_c, gOut_c, outValid_c} !== {e.s, e.c, e.p, e.g, 1'b1}) begin
                errors++;
                $display("FAIL vec_comb%0d got=%h want=%h", i,
                         {s_c, outC_c, pOut_c, gOut_c, outValid_c}, {e.s, e.c, e.p, e.g, 1'b1});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({s_r, outC_r, pOut_r, gOut_r, outValid_r} !== {e.s, e.c, e.p, e.g, 1'b1}) begin
                errors++;
                $display("FAIL vec_reg%0d got=%h want=%h", i,
                         {s_r, outC_r, pOut_r, gOut_r, outValid_r}, {e.s, e.c, e.p, e.g, 1'b1});
            end
        end
    endtask

    task automatic test_valid_pulse();
        @(negedge clk);
        a = 4'd7; b = 4'd9; inC = 1'b0; inValid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({s_r, outC_r, outValid_r} !== {4'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL pulse_result got=%h want=%h", {s_r, outC_r, outValid_r}, {4'h0, 1'b1, 1'b1});
        end
        @(negedge clk);
        inValid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outValid_r !== 1'b0) begin
            errors++;
            $display("FAIL pulse_drop got=%b want=0", outValid_r);
        end
    endtask

    task automatic test_midcycle_reset();
        @(negedge clk);
        a = 4'd15; b = 4'd15; inC = 1'b1; inValid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_r, outC_r, pOut_r, gOut_r, outValid_r} !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async got=%h want=00", {s_r, outC_r, pOut_r, gOut_r, outValid_r});
        end
`ifdef ADDER_CLA_OVF_EN
        checks++;
        if (ovf_r !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ovf got=%b want=0", ovf_r);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (outValid_r !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold got=%b want=0", outValid_r);
        end
        @(negedge clk);
        rst = 1'b1; inValid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (outValid_r !== 1'b0) begin
            errors++;
            $display("FAIL release_idle got=%b want=0", outValid_r);
        end
        @(negedge clk);
        inValid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (outValid_r !== 1'b1) begin
            errors++;
            $display("FAIL release_capture got=%b want=1", outValid_r);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        for (int k = 0; k < 512; k++) begin
            a = 4'(k >> 5); b = 4'((k >> 1) & 15); inC = 1'(k & 1); inValid = 1'b1;
            e = model(k >> 5, (k >> 1) & 15, k & 1);
            #1;
            checks++;
            if ({outC_c, s_c, pOut_c, gOut_c} !== {e.c, e.s, e.p, e.g}) begin
                errors++;
                $display("FAIL sweep a=%0d b=%0d cin=%0d got=%h want=%h", a, b, inC,
                         {outC_c, s_c, pOut_c, gOut_c}, {e.c, e.s, e.p, e.g});
            end
`ifdef ADDER_CLA_OVF_EN
            checks++;
            if (ovf_c !== e.ov) begin
                errors++;
                $display("FAIL sweep_ovf a=%0d b=%0d cin=%0d got=%b want=%b", a, b, inC, ovf_c, e.ov);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic v;
        int   av, bv, ci;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            av = int'($urandom_range(15)); bv = int'($urandom_range(15)); ci = int'($urandom_range(1));
            v  = 1'($urandom_range(1));
            a = 4'(av); b = 4'(bv); inC = 1'(ci); inValid = v;
            e = model(av, bv, ci);
            @(posedge clk);
            #1;
            checks++;
            if ({s_r, outC_r, pOut_r, gOut_r, outValid_r} !== {e.s, e.c, e.p, e.g, v}) begin
                errors++;
                $display("FAIL b2b%0d got=%h want=%h", n,
                         {s_r, outC_r, pOut_r, gOut_r, outValid_r}, {e.s, e.c, e.p, e.g, v});
            end
`ifdef ADDER_CLA_OVF_EN
            checks++;
            if (ovf_r !== e.ov) begin
                errors++;
                $display("FAIL b2b_ovf%0d got=%b want=%b", n, ovf_r, e.ov);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_valid_pulse();
        test_midcycle_reset();
        test_sweep();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
